// File: rtl/instr_fetch_unit_pkg.sv
// instr_fetch_unit_pkg: shared PCSrc encodings, IR field positions and fetch FSM states
package instr_fetch_unit_pkg;
    localparam logic [1:0] PC_SEQ = 2'b00;
    localparam logic [1:0] PC_BR  = 2'b01;
    localparam logic [1:0] PC_JR  = 2'b10;
    localparam logic [1:0] PC_J   = 2'b11;
    localparam int OP_MSB  = 31;
    localparam int OP_LSB  = 26;
    localparam int RS_MSB  = 25;
    localparam int RS_LSB  = 21;
    localparam int RT_MSB  = 20;
    localparam int RT_LSB  = 16;
    localparam int RD_MSB  = 15;
    localparam int RD_LSB  = 11;
    localparam int SA_MSB  = 10;
    localparam int SA_LSB  = 6;
    localparam int IMM_MSB = 15;
    localparam int TGT_MSB = 25;
    typedef enum logic {F_IDLE, F_REQ} fetch_state_e;
endpackage

// File: rtl/instr_fetch_unit_npc_mux.sv
// instr_fetch_unit_npc_mux: next-PC selection for sequential, branch, jr and j/jal
module instr_fetch_unit_npc_mux
    import instr_fetch_unit_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [31:0] ir,
    input  logic [31:0] rs_data,
    input  logic [1:0]  PCSrc,
    output logic [31:0] next_pc,
    output logic [31:0] pc_plus4
);
    logic [31:0] br_off;
    logic        unused_op;
    assign unused_op = &{1'b0, ir[OP_MSB:OP_LSB]};
    assign pc_plus4  = pc + 32'd4;
    assign br_off    = {{14{ir[IMM_MSB]}}, ir[IMM_MSB:0], 2'b00};
    always_comb begin
        next_pc = PCSrc == PC_SEQ ? pc_plus4 :
                  PCSrc == PC_BR  ? pc_plus4 + br_off :
                  PCSrc == PC_JR  ? rs_data :
                                    {pc_plus4[31:28], ir[TGT_MSB:0], 2'b00};
    end
endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC/IR registers, req/ack instruction fetch FSM and sticky error flags
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        PCWre,
    input  logic [1:0]  PCSrc,
    input  logic        IRWre,
    input  logic [31:0] rs_data,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ack,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic [31:0] ir,
    output logic [5:0]  opCode,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [4:0]  sa,
    output logic [15:0] imm16,
    output logic        ir_valid,
    output logic        fetch_stall,
    output logic        misalign_err,
    output logic        proto_err
);
    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d, ir_q, ir_d, next_pc;
    logic         ir_valid_q, ir_valid_d, misalign_q, misalign_d, proto_q, proto_d;

    instr_fetch_unit_npc_mux u_npc (
        .pc      (pc_q),
        .ir      (ir_q),
        .rs_data (rs_data),
        .PCSrc   (PCSrc),
        .next_pc (next_pc),
        .pc_plus4(pc_plus4)
    );

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        ir_valid_d = ir_valid_q;
        misalign_d = misalign_q;
        proto_d    = proto_q;
        if (state_q == F_IDLE) begin
            if (PCWre) begin
                pc_d       = {next_pc[31:2], 2'b00};
                ir_valid_d = 1'b0;
                misalign_d = misalign_q | (|next_pc[1:0]);
            end else if (IRWre && !ir_valid_q) begin
                state_d = F_REQ;
            end
        end else begin
            // A PC commit mid-fetch would desynchronise IR from PC, so it is dropped and flagged
            proto_d = proto_q | PCWre;
            if (imem_ack) begin
                ir_d       = imem_rdata;
                ir_valid_d = 1'b1;
                state_d    = F_IDLE;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q    <= F_IDLE;
            pc_q       <= RESET_PC;
            ir_q       <= 32'd0;
            ir_valid_q <= 1'b0;
            misalign_q <= 1'b0;
            proto_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            ir_valid_q <= ir_valid_d;
            misalign_q <= misalign_d;
            proto_q    <= proto_d;
        end
    end

    assign imem_req     = state_q == F_REQ;
    assign imem_addr    = pc_q;
    assign pc           = pc_q;
    assign ir           = ir_q;
    assign opCode       = ir_q[OP_MSB:OP_LSB];
    assign rs           = ir_q[RS_MSB:RS_LSB];
    assign rt           = ir_q[RT_MSB:RT_LSB];
    assign rd           = ir_q[RD_MSB:RD_LSB];
    assign sa           = ir_q[SA_MSB:SA_LSB];
    assign imm16        = ir_q[IMM_MSB:0];
    assign ir_valid     = ir_valid_q;
    assign fetch_stall  = (state_q == F_IDLE && IRWre && !ir_valid_q) || state_q == F_REQ;
    assign misalign_err = misalign_q;
    assign proto_err    = proto_q;
endmodule
